rf_control_sequencer: RTL and testbench
=======================================

// Module: rf_control_sequencer
// PURPOSE
//  Micro-sequencer directly upstream of the 8-entry register file (R1-R4, S1-S4).
//  - Accepts 16-bit instructions over a valid/ready handshake.
//  - Drives the register file's OutASel/OutBSel/FunSel/RegSel/ScrSel for 1 or 2 execute cycles.
//  - Drives the ALU function and the I-bus mux select.
//  - One instruction in flight at a time.
// PARAMETERS
//  IMM_W  8  immediate field width; zero-extended to 16 bits on Imm.
// PORTS
//  Clock       in   1   single clock; all state updates on rising edge
//  Reset       in   1   synchronous, active-high
//  InstrValid  in   1   instruction present on Instr
//  Instr       in   16  [15:12] opc, [11:9] dst, [8:6] srcA, [5:3] srcB, [7:0] imm
//  InstrReady  out  1   sequencer can accept an instruction (IDLE only)
//  OutASel     out  3   register-file port A select; 0-3 = R1-R4, 4-7 = S1-S4
//  OutBSel     out  3   register-file port B select; same encoding
//  FunSel      out  3   register-file function code
//  RegSel      out  4   active-low enables; bit3 = R1 .. bit0 = R4
//  ScrSel      out  4   active-low enables; bit3 = S1 .. bit0 = S4
//  AluFunSel   out  4   ALU operation
//  MuxSel      out  1   I-bus source: 0 = ALU result, 1 = Imm
//  Imm         out  16  zero-extended Instr[7:0], registered at accept
//  Done        out  1   1-cycle pulse in the write cycle of each instruction
//  Illegal     out  1   sticky illegal-opcode flag (only with RF_SEQ_TRAP_EN)
// BEHAVIOUR
//  Reset values (every output, applies mid-instruction, no partial write):
//   - state = IDLE, RegSel = ScrSel = 4'b1111, FunSel = OutASel = OutBSel = 0
//   - AluFunSel = 0, MuxSel = 0, Imm = 0, Done = 0, Illegal = 0, InstrReady = 1
//  Accept: InstrValid & InstrReady at a rising edge latches IR and Imm; next state T0.
//  States: IDLE -> T0 -> IDLE for 1-cycle ops; IDLE -> T0 -> T1 -> IDLE for 2-cycle ops.
//  Opcodes and execute cycles:
//   - 0 NOP: T0, no enable.
//   - 1 INC: T0, dst enable, FunSel = INC.
//   - 2 DEC: T0, dst enable, FunSel = DEC.
//   - 3 CLR: T0, dst enable, FunSel = CLR.
//   - 4 LDI: T0, dst enable, FunSel = LOAD, MuxSel = 1.
//   - 5 MOV: T0 OutASel = srcA, AluFunSel = PASSA; T1 same selects plus dst enable, FunSel = LOAD, MuxSel = 0.
//   - 6 ADD / 7 SUB: as MOV, with OutBSel = srcB and AluFunSel = ADD / SUB.
//   - 8-15: illegal.
//  Enables and selects:
//   - Exactly one enable bit is low in a write cycle; all enables are high otherwise.
//   - dst 0-3 clears RegSel bit (3 - dst); dst 4-7 clears ScrSel bit (7 - dst).
//  Timing:
//   - Done is high in the cycle the enable is asserted; NOP pulses Done in T0.
//   - InstrReady = 1 only in IDLE; no accept during T0 or T1.
//   - Throughput: 2 cycles per 1-cycle op, 3 cycles per 2-cycle op.
//  Outputs are registered decodes of state/IR; no combinational path from InstrValid or Instr to any output except InstrReady (state only).
//  srcA == srcB == dst is legal; the write occurs at the T1 edge using values read during T1.
// CONFIGURATION
//  RF_SEQ_TRAP_EN defined:
//   - Opcodes 8-15 set Illegal, which stays 1 until Reset.
//   - A trapping instruction performs no write and no Done pulse.
//   - Once Illegal = 1, InstrReady is held at 0.
//  RF_SEQ_TRAP_EN undefined:
//   - Opcodes 8-15 execute as NOP, with a Done pulse.
//   - Illegal is tied to 0.
// STRUCTURE
//  Package rf_seq_pkg:
//   - opcode constants OPC_*
//   - FunSel codes: FS_DEC = 3'b000, FS_INC = 3'b001, FS_LOAD = 3'b010, FS_CLR = 3'b011
//   - ALU codes: ALU_PASSA = 4'b0000, ALU_ADD = 4'b0100, ALU_SUB = 4'b0110
//   - state encoding
//  Sub-module rf_dst_decode (combinational): dst[2:0] + wr_en -> {RegSel, ScrSel}, active-low one-hot.
//  Top: FSM plus IR/Imm registers.
// TESTING
//  1. Reset, then LDI R2, 0x5A:
//     - T0: RegSel = 1011, ScrSel = 1111, FunSel = 010, MuxSel = 1, Imm = 0x005A, Done = 1.
//     - Next cycle: InstrReady = 1.
//  2. ADD S3 <- R1 + S4 (Instr = 0x6C38):
//     - T0: OutASel = 0, OutBSel = 7, AluFunSel = 0100, enables all high.
//     - T1: ScrSel = 1101, FunSel = 010, MuxSel = 0, Done = 1.
//  3. INC R4 with InstrValid held high for 10 cycles:
//     - Accept every 2nd cycle; InstrReady = 0 in each T0.
//     - Exactly 5 Done pulses.
//  4. Reset asserted during T0 of a MOV:
//     - Next cycle: RegSel = ScrSel = 1111, no Done, state IDLE, InstrReady = 1.
//  5. Opcode 0xF:
//     - With RF_SEQ_TRAP_EN: Illegal = 1 after T0; InstrReady stays 0 until Reset.
//     - Without: NOP behaviour, Done pulse, Illegal = 0.
//  6. Sweep dst 0-7 with CLR:
//     - Exactly one low bit across {RegSel, ScrSel} per write, matching the dst map.

Source files
------------

// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: shared constants, types and the per-cycle control decode for the
// register-file micro-sequencer (rf_control_sequencer).
package rf_seq_pkg;

  // Opcodes carried in Instr[15:12]; 8-15 are illegal.
  localparam logic [3:0] OPC_NOP = 4'd0;
  localparam logic [3:0] OPC_INC = 4'd1;
  localparam logic [3:0] OPC_DEC = 4'd2;
  localparam logic [3:0] OPC_CLR = 4'd3;
  localparam logic [3:0] OPC_LDI = 4'd4;
  localparam logic [3:0] OPC_MOV = 4'd5;
  localparam logic [3:0] OPC_ADD = 4'd6;
  localparam logic [3:0] OPC_SUB = 4'd7;

  // Register-file function codes.
  localparam logic [2:0] FS_DEC  = 3'b000;
  localparam logic [2:0] FS_INC  = 3'b001;
  localparam logic [2:0] FS_LOAD = 3'b010;
  localparam logic [2:0] FS_CLR  = 3'b011;

  // ALU function codes.
  localparam logic [3:0] ALU_PASSA = 4'b0000;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;

  // Sequencer state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_T0   = 2'd1;
  localparam logic [1:0] ST_T1   = 2'd2;

  // Everything the sequencer drives in one cycle, before the destination
  // index is expanded into the active-low RegSel/ScrSel enables.
  typedef struct packed {
    logic [2:0] out_a;
    logic [2:0] out_b;
    logic [2:0] fun_sel;
    logic [3:0] alu_fun;
    logic       mux_sel;
    logic       done;
    logic       wr_en;
    logic [2:0] dst;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Register-to-register ops read in T0 and write in T1.
  function automatic logic is_two_cycle(input logic [3:0] opc);
    return (opc == OPC_MOV) || (opc == OPC_ADD) || (opc == OPC_SUB);
  endfunction

  // ALU read-side controls shared by T0 and T1 of a two-cycle op. MOV only
  // reads port A, so port B stays at its idle value.
  function automatic ctrl_t read_selects(input ctrl_t base, input logic [15:0] ir);
    ctrl_t c;
    c       = base;
    c.out_a = ir[8:6];
    case (ir[15:12])
      OPC_ADD: begin
        c.out_b   = ir[5:3];
        c.alu_fun = ALU_ADD;
      end
      OPC_SUB: begin
        c.out_b   = ir[5:3];
        c.alu_fun = ALU_SUB;
      end
      default: c.alu_fun = ALU_PASSA;
    endcase
    return c;
  endfunction

  // Control word for a given sequencer state and instruction register.
  // trap_en selects whether illegal opcodes trap silently or act as NOP.
  function automatic ctrl_t decode_ctrl(input logic [1:0]  state,
                                        input logic [15:0] ir,
                                        input logic        trap_en);
    ctrl_t      c;
    logic [3:0] opc;
    opc   = ir[15:12];
    c     = CTRL_IDLE;
    c.dst = ir[11:9];
    case (state)
      ST_T0: begin
        case (opc)
          OPC_NOP: c.done = 1'b1;
          OPC_INC: begin
            c.wr_en   = 1'b1;
            c.fun_sel = FS_INC;
            c.done    = 1'b1;
          end
          OPC_DEC: begin
            c.wr_en   = 1'b1;
            c.fun_sel = FS_DEC;
            c.done    = 1'b1;
          end
          OPC_CLR: begin
            c.wr_en   = 1'b1;
            c.fun_sel = FS_CLR;
            c.done    = 1'b1;
          end
          OPC_LDI: begin
            c.wr_en   = 1'b1;
            c.fun_sel = FS_LOAD;
            c.mux_sel = 1'b1;
            c.done    = 1'b1;
          end
          OPC_MOV, OPC_ADD, OPC_SUB: c = read_selects(c, ir);
          // Illegal opcodes: a silent trap, or a plain NOP with its Done pulse.
          default: c.done = ~trap_en;
        endcase
      end
      ST_T1: begin
        if (is_two_cycle(opc)) begin
          c         = read_selects(c, ir);
          c.wr_en   = 1'b1;
          c.fun_sel = FS_LOAD;
          c.mux_sel = 1'b0;
          c.done    = 1'b1;
        end
      end
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rf_control_sequencer_dst_decode.sv
// rf_dst_decode: expands a 3-bit destination index into the register file's
// active-low one-hot enables. dst 0-3 -> R1-R4 (RegSel bit 3-dst),
// dst 4-7 -> S1-S4 (ScrSel bit 7-dst). No enable is low unless wr_en is set.
module rf_dst_decode
  import rf_seq_pkg::*;
(
  input  logic [2:0] dst,
  input  logic       wr_en,
  output logic [3:0] reg_sel,
  output logic [3:0] scr_sel
);

  logic [3:0] onehot;

  // Bit 3 is the first register of each bank, so the index counts down from the MSB.
  assign onehot = 4'b1000 >> dst[1:0];

  // Route the one-hot to whichever bank dst[2] selects; the other bank stays idle.
  always_comb begin
    // NOTE: both outputs get a default before any branch so no path leaves them unassigned (no latch).
    reg_sel = 4'b1111;
    scr_sel = 4'b1111;
    if (wr_en) begin
      if (dst[2]) scr_sel = ~onehot;
      else        reg_sel = ~onehot;
    end
  end

endmodule

// File: rtl/rf_control_sequencer.sv
// rf_control_sequencer: micro-sequencer feeding the 8-entry register file
// (R1-R4, S1-S4) and the ALU. Accepts one 16-bit instruction at a time over
// InstrValid/InstrReady and runs it for one (T0) or two (T0, T1) cycles.
// All outputs except InstrReady are flops loaded with the decode of the
// next state and next instruction register, so Instr/InstrValid never reach
// an output combinationally.
// Build option: define RF_SEQ_TRAP_EN to make opcodes 8-15 set a sticky
// Illegal flag (no write, no Done, input blocked until Reset); otherwise they
// execute as NOP and Illegal is tied low.
module rf_control_sequencer
  import rf_seq_pkg::*;
#(
  parameter int IMM_W = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        InstrValid,
  input  logic [15:0] Instr,
  output logic        InstrReady,
  output logic [2:0]  OutASel,
  output logic [2:0]  OutBSel,
  output logic [2:0]  FunSel,
  output logic [3:0]  RegSel,
  output logic [3:0]  ScrSel,
  output logic [3:0]  AluFunSel,
  output logic        MuxSel,
  output logic [15:0] Imm,
  output logic        Done,
  output logic        Illegal
);

`ifdef RF_SEQ_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] ir;
  logic [15:0] ir_nxt;
  logic        accept;
  logic        illegal_q;
  ctrl_t       ctrl_nxt;
  logic [3:0]  reg_sel_nxt;
  logic [3:0]  scr_sel_nxt;

  // Ready depends only on registered state: idle and not trapped.
  assign InstrReady = (state == ST_IDLE) && !illegal_q;
  assign accept     = InstrValid && InstrReady;
  assign Illegal    = illegal_q;

  // Next state and next instruction register.
  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_T0;
          ir_nxt    = Instr;
        end
      end
      ST_T0:   state_nxt = is_two_cycle(ir[15:12]) ? ST_T1 : ST_IDLE;
      ST_T1:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control word for the cycle about to start; registered below.
  assign ctrl_nxt = decode_ctrl(state_nxt, ir_nxt, TRAP_EN);

  rf_dst_decode u_dst_decode (
    .dst     (ctrl_nxt.dst),
    .wr_en   (ctrl_nxt.wr_en),
    .reg_sel (reg_sel_nxt),
    .scr_sel (scr_sel_nxt)
  );

  // State, IR, Imm and output registers; Reset aborts any instruction in flight.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      state     <= ST_IDLE;
      ir        <= '0;
      Imm       <= '0;
      OutASel   <= '0;
      OutBSel   <= '0;
      FunSel    <= '0;
      AluFunSel <= '0;
      MuxSel    <= 1'b0;
      Done      <= 1'b0;
      RegSel    <= 4'b1111;
      ScrSel    <= 4'b1111;
    end else begin
      state     <= state_nxt;
      ir        <= ir_nxt;
      if (accept) Imm <= {{(16 - IMM_W){1'b0}}, Instr[IMM_W-1:0]};
      OutASel   <= ctrl_nxt.out_a;
      OutBSel   <= ctrl_nxt.out_b;
      FunSel    <= ctrl_nxt.fun_sel;
      AluFunSel <= ctrl_nxt.alu_fun;
      MuxSel    <= ctrl_nxt.mux_sel;
      Done      <= ctrl_nxt.done;
      RegSel    <= reg_sel_nxt;
      ScrSel    <= scr_sel_nxt;
    end
  end

`ifdef RF_SEQ_TRAP_EN
  // Sticky trap flag: set as an illegal instruction leaves T0, cleared only by Reset.
  always_ff @(posedge Clock) begin
    if (Reset)                                illegal_q <= 1'b0;
    else if ((state == ST_T0) && ir[15])      illegal_q <= 1'b1;
  end
`else
  assign illegal_q = 1'b0;
`endif

endmodule

// File: tb/tb_rf_control_sequencer.sv
// Bench for rf_control_sequencer. Stimulus pushes the expected write-cycle
// controls into a scoreboard queue; a negedge monitor pops one entry per Done
// pulse and compares it. X fields in an expected entry are don't-care.
module tb_rf_control_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        InstrValid = 1'b0;
  logic [15:0] Instr = '0;
  logic        InstrReady;
  logic [2:0]  OutASel;
  logic [2:0]  OutBSel;
  logic [2:0]  FunSel;
  logic [3:0]  RegSel;
  logic [3:0]  ScrSel;
  logic [3:0]  AluFunSel;
  logic        MuxSel;
  logic [15:0] Imm;
  logic        Done;
  logic        Illegal;

  rf_control_sequencer #(.IMM_W(8)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .InstrValid (InstrValid),
    .Instr      (Instr),
    .InstrReady (InstrReady),
    .OutASel    (OutASel),
    .OutBSel    (OutBSel),
    .FunSel     (FunSel),
    .RegSel     (RegSel),
    .ScrSel     (ScrSel),
    .AluFunSel  (AluFunSel),
    .MuxSel     (MuxSel),
    .Imm        (Imm),
    .Done       (Done),
    .Illegal    (Illegal)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic [3:0]  reg_sel;
    logic [3:0]  scr_sel;
    logic [2:0]  fun_sel;
    logic        mux_sel;
    logic [2:0]  out_a;
    logic [2:0]  out_b;
    logic [3:0]  alu;
    logic [15:0] imm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_opt(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (!$isunknown(exp)) check(name, act, exp);
  endtask

  function automatic exp_t mk(input string name, input logic [3:0] rs, input logic [3:0] ss,
                              input logic [2:0] fs, input logic mx, input logic [2:0] oa,
                              input logic [2:0] ob, input logic [3:0] alu, input logic [15:0] imm);
    exp_t e;
    e.name = name; e.reg_sel = rs; e.scr_sel = ss; e.fun_sel = fs; e.mux_sel = mx;
    e.out_a = oa; e.out_b = ob; e.alu = alu; e.imm = imm;
    return e;
  endfunction

  // Monitor: one scoreboard entry per Done pulse; enables must be idle otherwise.
  always @(negedge Clock) begin : monitor
    exp_t e;
    if (!Reset) begin
      if (Done === 1'b1) begin
        done_count++;
        if (sb.size() == 0) begin
          check("unexpected_done", {31'b0, Done}, 32'd0);
        end else begin
          e = sb.pop_front();
          check_opt({e.name, ".RegSel"},    {28'b0, RegSel},    {28'b0, e.reg_sel});
          check_opt({e.name, ".ScrSel"},    {28'b0, ScrSel},    {28'b0, e.scr_sel});
          check_opt({e.name, ".FunSel"},    {29'b0, FunSel},    {29'b0, e.fun_sel});
          check_opt({e.name, ".MuxSel"},    {31'b0, MuxSel},    {31'b0, e.mux_sel});
          check_opt({e.name, ".OutASel"},   {29'b0, OutASel},   {29'b0, e.out_a});
          check_opt({e.name, ".OutBSel"},   {29'b0, OutBSel},   {29'b0, e.out_b});
          check_opt({e.name, ".AluFunSel"}, {28'b0, AluFunSel}, {28'b0, e.alu});
          check_opt({e.name, ".Imm"},       {16'b0, Imm},       {16'b0, e.imm});
        end
      end else begin
        check("idle_enables", {24'b0, RegSel, ScrSel}, 32'h0000_00FF);
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Hold Reset for two edges, check every output's reset value, release.
  task automatic do_reset();
    Reset      = 1'b1;
    InstrValid = 1'b0;
    tick();
    tick();
    @(negedge Clock);
    check("rst.RegSel",     {28'b0, RegSel},    32'hF);
    check("rst.ScrSel",     {28'b0, ScrSel},    32'hF);
    check("rst.FunSel",     {29'b0, FunSel},    32'd0);
    check("rst.OutASel",    {29'b0, OutASel},   32'd0);
    check("rst.OutBSel",    {29'b0, OutBSel},   32'd0);
    check("rst.AluFunSel",  {28'b0, AluFunSel}, 32'd0);
    check("rst.MuxSel",     {31'b0, MuxSel},    32'd0);
    check("rst.Imm",        {16'b0, Imm},       32'd0);
    check("rst.Done",       {31'b0, Done},      32'd0);
    check("rst.Illegal",    {31'b0, Illegal},   32'd0);
    check("rst.InstrReady", {31'b0, InstrReady}, 32'd1);
    tick();
    Reset = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    for (int k = 0; k < 20 && !InstrReady; k++) tick();
    check({name, ".ready_wait"}, {31'b0, InstrReady}, 32'd1);
  endtask

  // Present one instruction for exactly one accepting edge; returns at edge+1 (in T0).
  task automatic issue(input string name, input logic [15:0] ins);
    wait_ready(name);
    Instr      = ins;
    InstrValid = 1'b1;
    tick();
    InstrValid = 1'b0;
  endtask

  // CLR sweep: expected {RegSel, ScrSel} for dst 0..7.
  logic [7:0] clr_map [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  initial begin : stimulus
    int base;
    do_reset();

    // LDI R2, 0x5A
    sb.push_back(mk("ldi_r2", 4'b1011, 4'b1111, 3'b010, 1'b1, 3'bx, 3'bx, 4'bx, 16'h005A));
    issue("ldi_r2", 16'h425A);
    @(negedge Clock);
    check("ldi.t0_ready", {31'b0, InstrReady}, 32'd0);
    @(negedge Clock);
    check("ldi.after_ready", {31'b0, InstrReady}, 32'd1);

    // ADD S3 <- R1 + S4
    sb.push_back(mk("add_s3", 4'b1111, 4'b1101, 3'b010, 1'b0, 3'd0, 3'd7, 4'b0100, 16'h0038));
    issue("add_s3", 16'h6C38);
    @(negedge Clock);
    check("add.t0_OutASel",   {29'b0, OutASel},   32'd0);
    check("add.t0_OutBSel",   {29'b0, OutBSel},   32'd7);
    check("add.t0_AluFunSel", {28'b0, AluFunSel}, 32'h4);
    check("add.t0_Done",      {31'b0, Done},      32'd0);
    check("add.t0_ready",     {31'b0, InstrReady}, 32'd0);
    @(negedge Clock);
    check("add.t1_ready",     {31'b0, InstrReady}, 32'd0);

    // MOV S1 <- R3
    sb.push_back(mk("mov_s1", 4'b1111, 4'b0111, 3'b010, 1'b0, 3'd2, 3'bx, 4'b0000, 16'h0080));
    issue("mov_s1", 16'h5880);

    // SUB S2 <- S2 - S2 (src and dst all the same register)
    sb.push_back(mk("sub_s2", 4'b1111, 4'b1011, 3'b010, 1'b0, 3'd5, 3'd5, 4'b0110, 16'h0068));
    issue("sub_s2", 16'h7B68);

    // DEC R1, NOP
    sb.push_back(mk("dec_r1", 4'b0111, 4'b1111, 3'b000, 1'bx, 3'bx, 3'bx, 4'bx, 16'h0011));
    issue("dec_r1", 16'h2011);
    sb.push_back(mk("nop", 4'b1111, 4'b1111, 3'bx, 1'bx, 3'bx, 3'bx, 4'bx, 16'h0033));
    issue("nop", 16'h0033);

    // INC R4 with InstrValid held for 10 edges: accept every second edge.
    wait_ready("inc_burst");
    base = done_count;
    for (int i = 0; i < 5; i++)
      sb.push_back(mk("inc_r4", 4'b1110, 4'b1111, 3'b001, 1'bx, 3'bx, 3'bx, 4'bx, 16'h0007));
    Instr      = 16'h1607;
    InstrValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      check("burst.ready", {31'b0, InstrReady}, (i % 2 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    InstrValid = 1'b0;
    tick();
    tick();
    check("burst.done_pulses", done_count - base, 32'd5);

    // Reset during T0 of a MOV: no write, no Done, back to IDLE.
    issue("mov_abort", 16'h5880);
    Reset = 1'b1;
    tick();
    @(negedge Clock);
    check("abort.RegSel",     {28'b0, RegSel},     32'hF);
    check("abort.ScrSel",     {28'b0, ScrSel},     32'hF);
    check("abort.Done",       {31'b0, Done},       32'd0);
    check("abort.InstrReady", {31'b0, InstrReady}, 32'd1);
    tick();
    Reset = 1'b0;
    tick();
    tick();

    // Opcode 0xF
`ifdef RF_SEQ_TRAP_EN
    issue("trap", 16'hF0A5);
    @(negedge Clock);
    check("trap.t0_Done", {31'b0, Done}, 32'd0);
    tick();
    Instr      = 16'h1607;
    InstrValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      check("trap.Illegal",    {31'b0, Illegal},    32'd1);
      check("trap.InstrReady", {31'b0, InstrReady}, 32'd0);
      tick();
    end
    InstrValid = 1'b0;
    do_reset();
`else
    sb.push_back(mk("opc_f_nop", 4'b1111, 4'b1111, 3'bx, 1'bx, 3'bx, 3'bx, 4'bx, 16'h00A5));
    issue("opc_f", 16'hF0A5);
    tick();
    @(negedge Clock);
    check("opc_f.Illegal",    {31'b0, Illegal},    32'd0);
    check("opc_f.InstrReady", {31'b0, InstrReady}, 32'd1);
    tick();
`endif

    // CLR sweep over every destination.
    for (int d = 0; d < 8; d++) begin
      sb.push_back(mk($sformatf("clr_dst%0d", d), clr_map[d][7:4], clr_map[d][3:0],
                      3'b011, 1'bx, 3'bx, 3'bx, 4'bx, {13'b0, 3'(d)}));
      issue("clr", {4'h3, 3'(d), 6'b0, 3'(d)});
    end

    tick();
    tick();
    tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
